// File: rtl/eth_header_tx.sv
// GMII transmit framer: preamble, SFD, Ethernet header, streamed payload with
// zero padding to the minimum length, abort on underrun/overrun, then inter-frame gap.
module eth_header_tx #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int IFG_CYCLES   = 16
) (
  input  logic        mac_gmii_tx_clk,
  input  logic        mac_gmii_tx_rstn,
  input  logic        start,
  input  logic [47:0] mac_d_addr,
  input  logic [47:0] mac_s_addr,
  input  logic [15:0] eth_type,
  input  logic [7:0]  payload_tdata,
  input  logic        payload_tvalid,
  input  logic        payload_tlast,
  output logic        payload_tready,
  output logic [7:0]  mac_gmii_txd,
  output logic        mac_gmii_tx_en,
  output logic        mac_gmii_tx_er,
  output logic        busy,
  output logic        frame_last,
  output logic        frame_abort
);

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    SFD,
    MAC_DESTINATION,
    MAC_SOURCE,
    ETH_TYPE,
    PAYLOAD,
    PAD,
    IFG
  } state_t;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [10:0] r_payCnt;
  logic [15:0] r_ifgCnt;
  logic [47:0] r_dAddr;
  logic [47:0] r_sAddr;
  logic [15:0] r_ethType;

  logic [10:0] w_payNext;
  logic        w_overrun;

  assign w_payNext      = r_payCnt + 11'd1;
  assign w_overrun      = (r_payCnt == MAX_P);
  assign payload_tready = (r_state == PAYLOAD) && !w_overrun;

  // The state names the byte emitted at the next edge, so every output is
  // registered while tready can rise one cycle before the first payload byte.
  always_ff @(posedge mac_gmii_tx_clk or negedge mac_gmii_tx_rstn) begin
    if (!mac_gmii_tx_rstn) begin
      r_state        <= IDLE;
      r_cnt          <= 8'd0;
      r_payCnt       <= 11'd0;
      r_ifgCnt       <= 16'd0;
      r_dAddr        <= 48'd0;
      r_sAddr        <= 48'd0;
      r_ethType      <= 16'd0;
      mac_gmii_txd   <= 8'h00;
      mac_gmii_tx_en <= 1'b0;
      mac_gmii_tx_er <= 1'b0;
      busy           <= 1'b0;
      frame_last     <= 1'b0;
      frame_abort    <= 1'b0;
    end else begin
      frame_last     <= 1'b0;
      frame_abort    <= 1'b0;
      mac_gmii_tx_er <= 1'b0;
      case (r_state)
        IDLE: begin
          mac_gmii_txd   <= 8'h00;
          mac_gmii_tx_en <= 1'b0;
          if (start) begin
            r_dAddr        <= mac_d_addr;
            r_sAddr        <= mac_s_addr;
            r_ethType      <= eth_type;
            r_cnt          <= 8'd1;
            r_payCnt       <= 11'd0;
            busy           <= 1'b1;
            mac_gmii_txd   <= 8'h55;
            mac_gmii_tx_en <= 1'b1;
            r_state        <= (PREAMBLE_LEN == 1) ? SFD : PREAMBLE;
          end
        end
        PREAMBLE: begin
          mac_gmii_txd   <= 8'h55;
          mac_gmii_tx_en <= 1'b1;
          r_cnt          <= r_cnt + 8'd1;
          if (r_cnt == PRE_LAST) r_state <= SFD;
        end
        SFD: begin
          mac_gmii_txd   <= 8'hD5;
          mac_gmii_tx_en <= 1'b1;
          r_cnt          <= 8'd0;
          r_state        <= MAC_DESTINATION;
        end
        MAC_DESTINATION: begin
          mac_gmii_txd   <= r_dAddr[47:40];
          mac_gmii_tx_en <= 1'b1;
          r_dAddr        <= {r_dAddr[39:0], 8'h00};
          if (r_cnt == 8'd5) begin
            r_cnt   <= 8'd0;
            r_state <= MAC_SOURCE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        MAC_SOURCE: begin
          mac_gmii_txd   <= r_sAddr[47:40];
          mac_gmii_tx_en <= 1'b1;
          r_sAddr        <= {r_sAddr[39:0], 8'h00};
          if (r_cnt == 8'd5) begin
            r_cnt   <= 8'd0;
            r_state <= ETH_TYPE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ETH_TYPE: begin
          mac_gmii_txd   <= r_ethType[15:8];
          mac_gmii_tx_en <= 1'b1;
          r_ethType      <= {r_ethType[7:0], 8'h00};
          r_cnt          <= r_cnt + 8'd1;
          if (r_cnt == 8'd1) r_state <= PAYLOAD;
        end
        PAYLOAD: begin
          mac_gmii_tx_en <= 1'b1;
          // A valid byte (including a tlast byte) always beats the underrun check.
          if (w_overrun || !payload_tvalid) begin
            mac_gmii_txd   <= 8'h00;
            mac_gmii_tx_er <= 1'b1;
            frame_abort    <= 1'b1;
            r_state        <= IFG;
          end else begin
            mac_gmii_txd <= payload_tdata;
            r_payCnt     <= w_payNext;
            if (payload_tlast) begin
              if (w_payNext >= MIN_P) begin
                frame_last <= 1'b1;
                r_state    <= IFG;
              end else begin
                r_state <= PAD;
              end
            end
          end
        end
        PAD: begin
          mac_gmii_txd   <= 8'h00;
          mac_gmii_tx_en <= 1'b1;
          r_payCnt       <= w_payNext;
          if (w_payNext == MIN_P) begin
            frame_last <= 1'b1;
            r_state    <= IFG;
          end
        end
        IFG: begin
          mac_gmii_txd   <= 8'h00;
          mac_gmii_tx_en <= 1'b0;
          if (r_ifgCnt == IFG_LAST) begin
            r_ifgCnt <= 16'd0;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_ifgCnt <= r_ifgCnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_header_tx.sv
// Directed bench for eth_header_tx: expected GMII bytes are queued when a frame
// is requested and popped by a monitor whenever tx_en is high.
module tb_eth_header_tx;

  localparam int PRE  = 7;
  localparam int MINP = 46;
  localparam int IFG  = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start;
  logic [47:0] mac_d_addr;
  logic [47:0] mac_s_addr;
  logic [15:0] eth_type;
  logic [7:0]  payload_tdata;
  logic        payload_tvalid;
  logic        payload_tlast;
  logic        payload_tready;
  logic [7:0]  mac_gmii_txd;
  logic        mac_gmii_tx_en;
  logic        mac_gmii_tx_er;
  logic        busy;
  logic        frame_last;
  logic        frame_abort;

  eth_header_tx dut (
    .mac_gmii_tx_clk  (clk),
    .mac_gmii_tx_rstn (rstn),
    .start            (start),
    .mac_d_addr       (mac_d_addr),
    .mac_s_addr       (mac_s_addr),
    .eth_type         (eth_type),
    .payload_tdata    (payload_tdata),
    .payload_tvalid   (payload_tvalid),
    .payload_tlast    (payload_tlast),
    .payload_tready   (payload_tready),
    .mac_gmii_txd     (mac_gmii_txd),
    .mac_gmii_tx_en   (mac_gmii_tx_en),
    .mac_gmii_tx_er   (mac_gmii_tx_er),
    .busy             (busy),
    .frame_last       (frame_last),
    .frame_abort      (frame_abort)
  );

  always #4 clk = ~clk;

  int          nVec = 0;
  int          nMis = 0;
  logic [10:0] expQ[$];
  logic [7:0]  payMem[0:2047];
  logic        lastMem[0:2047];
  int          enRun = 0;
  int          idleRun = 0;
  int          lastEnRun = 0;
  int          lastGap = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every tx_en byte is {er,last,abort,txd} against the scoreboard head.
  always @(negedge clk) begin : monitor
    logic [10:0] e;
    if (rstn) begin
      if (mac_gmii_tx_en) begin
        if (idleRun > 0) lastGap = idleRun;
        idleRun = 0;
        enRun++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_byte",
                      {21'd0, mac_gmii_tx_er, frame_last, frame_abort, mac_gmii_txd}, 32'h800);
        end else begin
          e = expQ.pop_front();
          checkOutput("tx_byte",
                      {21'd0, mac_gmii_tx_er, frame_last, frame_abort, mac_gmii_txd}, {21'd0, e});
        end
      end else begin
        if (enRun > 0) begin
          lastEnRun = enRun;
          enRun = 0;
        end
        idleRun++;
        checkOutput("idle_flags", {29'd0, mac_gmii_tx_er, frame_last, frame_abort}, 32'd0);
      end
    end else begin
      enRun = 0;
      idleRun = 0;
    end
  end

  task automatic pushFrame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                           input int base, input int len, input int underAt, input bit ovr);
    int nData;
    for (int i = 0; i < len; i++) begin
      payMem[base+i]  = 8'($urandom);
      lastMem[base+i] = !ovr && (i == len - 1);
    end
    for (int i = 0; i < PRE; i++) expQ.push_back({3'b000, 8'h55});
    expQ.push_back({3'b000, 8'hD5});
    for (int b = 5; b >= 0; b--) expQ.push_back({3'b000, d[8*b +: 8]});
    for (int b = 5; b >= 0; b--) expQ.push_back({3'b000, s[8*b +: 8]});
    expQ.push_back({3'b000, t[15:8]});
    expQ.push_back({3'b000, t[7:0]});
    nData = ovr ? 1500 : ((underAt >= 0) ? underAt : len);
    for (int i = 0; i < nData; i++)
      expQ.push_back({1'b0, (!ovr && underAt < 0 && len >= MINP && i == len - 1), 1'b0, payMem[base+i]});
    if (ovr || underAt >= 0) begin
      expQ.push_back({1'b1, 1'b0, 1'b1, 8'h00});
    end else begin
      for (int i = len; i < MINP; i++) expQ.push_back({1'b0, (i == MINP - 1), 1'b0, 8'h00});
    end
  endtask

  // Presents a start request; nd/ns/nt overwrite the header inputs after capture.
  task automatic applyStimulus(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                               input bit relRst, input bit hold,
                               input logic [47:0] nd, input logic [47:0] ns, input logic [15:0] nt);
    mac_d_addr = d;
    mac_s_addr = s;
    eth_type   = t;
    start      = 1'b1;
    if (relRst) rstn = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    mac_d_addr = nd;
    mac_s_addr = ns;
    eth_type   = nt;
    checkOutput("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic feed(input int base, input int count, input int underAt, input int stopAt,
                      input bit ovr, input bit hold, output int readyCycle);
    int i;
    int c;
    bit acc;
    bit sawIdle;
    i = 0;
    c = 1;
    readyCycle = -1;
    sawIdle = 1'b0;
    payload_tdata  = payMem[base];
    payload_tlast  = lastMem[base];
    payload_tvalid = (underAt != 0);
    while (i < count) begin
      if (stopAt > 0 && c == stopAt) return;
      if (c > 4000) begin
        checkOutput("feed_timeout", 32'(i), 32'(count));
        return;
      end
      if (hold) begin
        if (!busy) sawIdle = 1'b1;
        else if (sawIdle) start = 1'b0;
      end
      acc = payload_tready;
      if (acc && readyCycle < 0) readyCycle = c;
      @(posedge clk); #1;
      c++;
      if (acc && !payload_tvalid) return;
      if (ovr && !acc && i == 1500) return;
      if (acc && payload_tvalid) begin
        i++;
        if (i < count) begin
          payload_tdata = payMem[base+i];
          payload_tlast = lastMem[base+i];
          if (i == underAt) payload_tvalid = 1'b0;
        end else begin
          payload_tvalid = 1'b0;
          payload_tlast  = 1'b0;
        end
      end
    end
  endtask

  task automatic waitIdle(output int sinceEn);
    sinceEn = 0;
    for (int k = 0; k < 3000; k++) begin
      if (mac_gmii_tx_en) sinceEn = 0;
      else sinceEn++;
      if (!busy) return;
      @(posedge clk); #1;
    end
    checkOutput("busy_fall_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rc;
    int se;
    logic [47:0] dA;
    logic [47:0] sA;
    start = 1'b0;
    mac_d_addr = 48'd0;
    mac_s_addr = 48'd0;
    eth_type = 16'd0;
    payload_tdata = 8'd0;
    payload_tvalid = 1'b0;
    payload_tlast = 1'b0;
    dA = 48'h02_11_22_33_44_55;
    sA = 48'h00_0A_35_01_02_03;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_txd",    32'(mac_gmii_txd),   32'd0);
    checkOutput("rst_tx_en",  32'(mac_gmii_tx_en), 32'd0);
    checkOutput("rst_tx_er",  32'(mac_gmii_tx_er), 32'd0);
    checkOutput("rst_tready", 32'(payload_tready), 32'd0);
    checkOutput("rst_busy",   32'(busy),           32'd0);
    checkOutput("rst_last",   32'(frame_last),     32'd0);
    checkOutput("rst_abort",  32'(frame_abort),    32'd0);

    // Broadcast ARP, 28 bytes padded to 46; start accepted on the first edge after reset release
    pushFrame(48'hFFFF_FFFF_FFFF, sA, 16'h0806, 0, 28, -1, 1'b0);
    applyStimulus(48'hFFFF_FFFF_FFFF, sA, 16'h0806, 1'b1, 1'b0,
                  48'({$urandom, $urandom}), 48'({$urandom, $urandom}), 16'($urandom));
    feed(0, 28, -1, 0, 1'b0, 1'b0, rc);
    checkOutput("arp_tready_cycle", 32'(rc), 32'd22);
    waitIdle(se);
    checkOutput("arp_ifg", 32'(se), 32'(IFG));
    checkOutput("arp_en_len", 32'(lastEnRun), 32'd68);
    checkOutput("arp_drained", 32'(expQ.size()), 32'd0);

    // IPv4, 100 bytes, no padding
    pushFrame(dA, sA, 16'h0800, 0, 100, -1, 1'b0);
    applyStimulus(dA, sA, 16'h0800, 1'b0, 1'b0, 48'd0, 48'd0, 16'd0);
    feed(0, 100, -1, 0, 1'b0, 1'b0, rc);
    checkOutput("ip_tready_cycle", 32'(rc), 32'd22);
    waitIdle(se);
    checkOutput("ip_ifg", 32'(se), 32'(IFG));
    checkOutput("ip_en_len", 32'(lastEnRun), 32'd122);
    checkOutput("ip_drained", 32'(expQ.size()), 32'd0);

    // Underrun at payload byte 10
    pushFrame(sA, dA, 16'h0800, 0, 60, 9, 1'b0);
    applyStimulus(sA, dA, 16'h0800, 1'b0, 1'b0, dA, sA, 16'h0806);
    feed(0, 60, 9, 0, 1'b0, 1'b0, rc);
    waitIdle(se);
    checkOutput("under_ifg", 32'(se), 32'(IFG));
    checkOutput("under_en_len", 32'(lastEnRun), 32'd32);
    checkOutput("under_drained", 32'(expQ.size()), 32'd0);

    // Overrun: 1501 bytes offered without tlast
    pushFrame(dA, sA, 16'h0800, 0, 1501, -1, 1'b1);
    applyStimulus(dA, sA, 16'h0800, 1'b0, 1'b0, 48'd0, 48'd0, 16'd0);
    feed(0, 1501, -1, 0, 1'b1, 1'b0, rc);
    waitIdle(se);
    checkOutput("over_ifg", 32'(se), 32'(IFG));
    checkOutput("over_en_len", 32'(lastEnRun), 32'd1523);
    checkOutput("over_drained", 32'(expQ.size()), 32'd0);

    // start held high: back-to-back frames, B's header applied while A is in flight
    pushFrame(dA, sA, 16'h0806, 0, 46, -1, 1'b0);
    pushFrame(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h0800, 46, 50, -1, 1'b0);
    applyStimulus(dA, sA, 16'h0806, 1'b0, 1'b1,
                  48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h0800);
    feed(0, 96, -1, 0, 1'b0, 1'b1, rc);
    waitIdle(se);
    checkOutput("b2b_gap", 32'(lastGap), 32'(IFG));
    checkOutput("b2b_en_len", 32'(lastEnRun), 32'd72);
    checkOutput("b2b_drained", 32'(expQ.size()), 32'd0);

    // Reset at cycle 30 of a frame, then a clean frame
    pushFrame(dA, sA, 16'h0800, 0, 50, -1, 1'b0);
    applyStimulus(dA, sA, 16'h0800, 1'b0, 1'b0, 48'd0, 48'd0, 16'd0);
    feed(0, 50, -1, 30, 1'b0, 1'b0, rc);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_tx_en",  32'(mac_gmii_tx_en), 32'd0);
    checkOutput("midrst_busy",   32'(busy),           32'd0);
    checkOutput("midrst_tready", 32'(payload_tready), 32'd0);
    checkOutput("midrst_txd",    32'(mac_gmii_txd),   32'd0);
    expQ.delete();
    payload_tvalid = 1'b0;
    payload_tlast  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pushFrame(sA, dA, 16'h0806, 0, 40, -1, 1'b0);
    applyStimulus(sA, dA, 16'h0806, 1'b1, 1'b0, dA, sA, 16'h0800);
    feed(0, 40, -1, 0, 1'b0, 1'b0, rc);
    checkOutput("post_tready_cycle", 32'(rc), 32'd22);
    waitIdle(se);
    checkOutput("post_ifg", 32'(se), 32'(IFG));
    checkOutput("post_en_len", 32'(lastEnRun), 32'd68);
    checkOutput("post_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/eth_header_tx.md
# eth_header_tx

Transmit-side framer for the GMII MAC path, mirroring header parsing on the receive side. On a start request it captures destination MAC, source MAC and EtherType, then emits preamble, SFD, the 14-byte Ethernet header, and the streamed payload, with zero padding to the minimum payload length. It sits between the ARP/IP transmit sources and the downstream FCS inserter, and enforces inter-frame gap before accepting the next frame.

## Interface
Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded
- MAX_PAYLOAD, 1500, payload byte limit; exceeding it aborts the frame
- IFG_CYCLES, 16, idle cycles after last byte (4 FCS + 12 IFG)

Ports:
- mac_gmii_tx_clk  in  1  transmit clock; the single clock of the block
- mac_gmii_tx_rstn  in  1  reset; asynchronous, active-low
- start  in  1  frame request; sampled only when busy=0
- mac_d_addr  in  48  destination MAC, captured on accepted start
- mac_s_addr  in  48  source MAC, captured on accepted start
- eth_type  in  16  EtherType (0x0806 ARP, 0x0800 IPv4), captured on accepted start
- payload_tdata  in  8  payload byte
- payload_tvalid  in  1  payload byte valid
- payload_tlast  in  1  last payload byte
- payload_tready  out  1  payload byte accepted when tvalid&tready
- mac_gmii_txd  out  8  GMII data, registered
- mac_gmii_tx_en  out  1  GMII enable, registered
- mac_gmii_tx_er  out  1  GMII error, registered
- busy  out  1  high from the cycle after an accepted start through the end of IFG
- frame_last  out  1  one-cycle pulse with the final byte on txd (for FCS inserter)
- frame_abort  out  1  one-cycle pulse with the tx_er byte of an aborted frame

## Operation
- States: IDLE, PREAMBLE, SFD, MAC_DESTINATION, MAC_SOURCE, ETH_TYPE, PAYLOAD, PAD, IFG.
- IDLE: start=1 latches mac_d_addr/mac_s_addr/eth_type into internal buffers and moves to PREAMBLE. Input changes after capture have no effect on the frame.
- PREAMBLE: PREAMBLE_LEN bytes 0x55. SFD: one byte 0xD5.
- MAC_DESTINATION and MAC_SOURCE: 6 bytes each, MSB first (bits [47:40] first). ETH_TYPE: [15:8], then [7:0].
- PAYLOAD: payload_tready = 1 (combinational from state). Each accepted byte is sent on txd. 11-bit payload counter increments per byte sent (payload and pad).
- tlast accepted with count+1 >= MIN_PAYLOAD -> that byte is final; frame_last is asserted with it, then IFG.
- tlast accepted with count+1 < MIN_PAYLOAD -> PAD: send 0x00 until count = MIN_PAYLOAD; frame_last is asserted with the last pad byte.
- Underrun (tvalid=0 while in PAYLOAD) -> send one byte txd=0x00 with tx_en=1 and tx_er=1, pulse frame_abort, go to IFG. No frame_last is asserted.
- Overrun (MAX_PAYLOAD bytes accepted without tlast) -> the next cycle is the tx_er byte, as for underrun.
- IFG: tx_en=0 for IFG_CYCLES cycles, then IDLE with busy=0.
- start outside IDLE is ignored (not queued).

## Timing
- Reset values: mac_gmii_txd=0x00, tx_en=0, tx_er=0, payload_tready=0, busy=0, frame_last=0, frame_abort=0, state IDLE, counters 0.
- Asserting reset clears all outputs immediately. Mid-frame reset truncates the frame without tx_er. After reset release, start is accepted on the first edge.
- Start sampled at edge 0 -> busy and the first 0x55 byte on txd from cycle 1.
- With PREAMBLE_LEN=7:
  - preamble on cycles 1-7, SFD on cycle 8
  - destination MAC on cycles 9-14, source MAC on cycles 15-20
  - EtherType on cycles 21-22
  - first payload byte on cycle 23
- payload_tready first rises in cycle 22. A byte accepted in cycle k appears on txd in cycle k+1.
- tx_en is contiguous from the first preamble byte to the final byte, except when a frame is aborted.
- Minimum frame is 68 tx_en cycles (8+14+46).
- busy falls exactly IFG_CYCLES cycles after the last tx_en=1 cycle. The earliest next start is sampled on the cycle busy=0, which gives its first byte IFG_CYCLES+1 cycles after the previous last byte.
- tlast with tvalid in the same cycle as an underrun check: a valid tlast byte wins and no abort occurs.

## Test plan
- Broadcast ARP: d=FF:FF:FF:FF:FF:FF, s=00:0A:35:01:02:03, type 0x0806, 28-byte payload -> txd 55×7, D5, FF×6, 00 0A 35 01 02 03, 08 06, 28 bytes, 00×18; tx_en for 68 cycles; frame_last on cycle 68.
- IPv4, 100-byte payload, no stalls -> 122 tx_en cycles; no padding; frame_last with the 100th byte; busy low 16 cycles later.
- Underrun: drop tvalid at payload byte 10 -> that cycle txd=00 with tx_en=1, tx_er=1, and frame_abort pulses; tx_en=0 next cycle; IFG follows.
- Overrun: 1501 bytes without tlast -> 1500 bytes sent, then a tx_er byte and frame_abort.
- start held high continuously -> back-to-back frames separated by exactly 16 tx_en=0 cycles; header fields changed mid-frame do not affect the frame in flight.
- Reset asserted at cycle 30 of a frame -> tx_en, busy and tready go to 0 immediately; after release a new start yields a complete, correct frame.
